instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 4: instruction buffer entries; power of two, 2..16.
REQ-003 SHALL have port Clk  input  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_req  output  1  fetch request valid.
REQ-006 SHALL have port imem_addr  output  32  fetch address, word aligned.
REQ-007 SHALL have port imem_gnt  input  1  memory accepted the request this cycle.
REQ-008 SHALL have port imem_rvalid  input  1  read data valid.
REQ-009 SHALL have port imem_rdata  input  32  instruction word.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump redirect from downstream.
REQ-011 SHALL have port redirect_pc  input  32  redirect target.
REQ-012 SHALL have port inst_valid  output  1  instruction offered to decode.
REQ-013 SHALL have port inst_data  output  32  instruction word feeding decode ReadData.
REQ-014 SHALL have port inst_pc  output  32  PC of inst_data.
REQ-015 SHALL have port inst_ready  input  1  decode accepts the instruction this cycle.
REQ-016 SHALL have port fetch_stall_cnt  output  32  decode-starved cycle count (see Configuration).

Function
REQ-017 SHALL keep a fetch PC; imem_addr SHALL equal the fetch PC with bits [1:0] = 0.
REQ-018 SHALL run FSM IDLE -> FETCH -> WAIT -> FETCH, plus DROP; IDLE lasts exactly one cycle after reset release.
REQ-019 FETCH: SHALL assert imem_req only when (buffer count + outstanding) < BUF_DEPTH; imem_gnt=1 -> PC += 4, go WAIT.
REQ-020 SHALL keep imem_req and imem_addr stable until imem_gnt; at most one request outstanding.
REQ-021 WAIT: imem_rvalid=1 -> push {PC of request, imem_rdata} into buffer, go FETCH in the same cycle edge.
REQ-022 Buffer SHALL be FIFO; inst_valid = not empty; inst_data/inst_pc = head entry; pop when inst_valid & inst_ready.
REQ-023 Push and pop in the same cycle SHALL both occur; count unchanged.
REQ-024 Request latency: first imem_req SHALL rise on the second rising edge after Reset_n deasserts; rvalid-to-inst_valid latency exactly one cycle.
REQ-025 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
REQ-026 redirect_valid=1 SHALL flush the buffer (inst_valid=0 next cycle), load PC <= {redirect_pc[31:2],2'b00}, and ignore inst_ready that cycle.
REQ-027 Redirect while a request is outstanding, or in the same cycle as imem_gnt, SHALL go DROP; DROP discards the next imem_rvalid, then goes FETCH.
REQ-028 Redirect in the same cycle as imem_rvalid in WAIT SHALL discard that response and go FETCH.
REQ-029 imem_rvalid outside WAIT/DROP SHALL be ignored.

Reset
REQ-030 Reset_n=0 SHALL asynchronously set PC=RESET_PC, FSM=IDLE, buffer empty, outstanding=0, imem_req=0, inst_valid=0, fetch_stall_cnt=0.
REQ-031 Reset mid-transaction SHALL abandon the outstanding request; its late rvalid after reset release SHALL be ignored (arrives in IDLE/FETCH).

Configuration
REQ-032 Macro FETCH_PERF_CNT_EN defined: fetch_stall_cnt SHALL increment each cycle inst_valid=0 after IDLE, saturating at 32'hFFFF_FFFF.
REQ-033 Macro undefined: no counter logic; fetch_stall_cnt SHALL be tied to 32'h0.

Structure
REQ-034 Shared package fetch_pkg SHALL hold the FSM state enum, the buffer entry struct {pc, inst}, and the RESET_PC default constant.
REQ-035 Buffer SHALL be a sub-module fetch_fifo (parameterised depth, push/pop/full/empty/count).

Verification
REQ-036 Reset release, imem_gnt=1 always, rvalid one cycle after gnt with rdata=32'h0000_0013 -> addrs 0x0,0x4,0x8; inst_pc sequence 0x0,0x4,0x8.
REQ-037 inst_ready=0 held -> exactly 4 entries buffered, imem_req stays 0, no further addresses issued.
REQ-038 Redirect to 32'h0000_1002 while WAIT -> next rvalid dropped, next imem_addr=32'h0000_1000, buffer emptied.
REQ-039 Redirect coincident with imem_rvalid -> response not pushed, inst_valid=0 next cycle.
REQ-040 RESET_PC=32'hFFFF_FFF8 -> addrs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-041 FETCH_PERF_CNT_EN defined, imem_gnt=0 for 10 cycles after IDLE -> fetch_stall_cnt=10; undefined -> 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Instruction memory is word addressed; low two bits never reach the bus.
    function automatic logic [31:0] alignPc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer FIFO with flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           pushData,
    input  logic                   pop,
    output fetch_entry_t           popData,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rdPtr;
    logic [AW-1:0]  wrPtr;
    logic [AW:0]    cnt;
    logic           doPush;
    logic           doPop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW + 1)'(DEPTH));
    assign count   = cnt;
    assign popData = mem[rdPtr];
    assign doPop   = pop && !empty;
    assign doPush  = push && (!full || doPop);

    // Pointers and occupancy; a flush discards everything at once
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rdPtr <= '0;
            wrPtr <= '0;
            cnt   <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            cnt   <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage needs no reset; occupancy decides what is visible
    always_ff @(posedge clk) begin
        if (doPush && !flush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch unit; FETCH_PERF_CNT_EN enables the stall counter
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic [31:0] fetch_stall_cnt
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t  state;
    fetch_state_t  stateNext;
    logic [31:0]   pcQ;
    logic [31:0]   pcNext;
    logic [31:0]   reqPcQ;
    logic          reqQ;
    logic          reqNext;
    logic          accept;
    logic          push;
    logic          pop;
    logic [CW-1:0] fifoCount;
    logic [CW-1:0] countNext;
    logic          fifoFull;
    logic          fifoEmpty;
    fetch_entry_t  pushEntry;
    fetch_entry_t  headEntry;

    // A request is taken only when it is actually on the bus in FETCH.
    assign accept    = (state == ST_FETCH) && reqQ && imem_gnt;
    // Responses only land in WAIT; a coincident redirect discards them.
    assign push      = (state == ST_WAIT) && imem_rvalid && !redirect_valid && !fifoFull;
    assign pop       = !fifoEmpty && inst_ready && !redirect_valid;
    assign pushEntry = '{pc: reqPcQ, inst: imem_rdata};

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk      (Clk),
        .rstN     (Reset_n),
        .flush    (redirect_valid),
        .push     (push),
        .pushData (pushEntry),
        .pop      (pop),
        .popData  (headEntry),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    // Buffer occupancy after this edge, used to decide the next request
    always_comb begin
        countNext = fifoCount;
        if (redirect_valid)    countNext = '0;
        else if (push && !pop) countNext = fifoCount + 1'b1;
        else if (!push && pop) countNext = fifoCount - 1'b1;
    end

    // Next state, next fetch PC and next request flag
    always_comb begin
        stateNext = state;
        pcNext    = pcQ;
        case (state)
            ST_IDLE:  stateNext = ST_FETCH;
            ST_FETCH: begin
                if (accept) begin
                    stateNext = redirect_valid ? ST_DROP : ST_WAIT;
                    pcNext    = pcQ + 32'd4;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid)         stateNext = ST_FETCH;
                else if (redirect_valid) stateNext = ST_DROP;
            end
            ST_DROP: begin
                if (imem_rvalid) stateNext = ST_FETCH;
            end
            default: stateNext = ST_IDLE;
        endcase
        if (redirect_valid) pcNext = alignPc(redirect_pc);
        // Registered request: it stays put while FETCH waits for a grant,
        // because the buffer can only drain while nothing is outstanding.
        reqNext = (state != ST_IDLE) && (stateNext == ST_FETCH) &&
                  (countNext < CW'(BUF_DEPTH));
    end

    // State, fetch PC, request flag and PC of the in-flight request
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= ST_IDLE;
            pcQ    <= RESET_PC;
            reqQ   <= 1'b0;
            reqPcQ <= '0;
        end else begin
            state <= stateNext;
            pcQ   <= pcNext;
            reqQ  <= reqNext;
            if (accept) reqPcQ <= pcQ;
        end
    end

    assign imem_req   = reqQ;
    assign imem_addr  = alignPc(pcQ);
    assign inst_valid = !fifoEmpty;
    assign inst_data  = headEntry.inst;
    assign inst_pc    = headEntry.pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stallCnt;

    // Count cycles decode is starved once fetching has started, saturating
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stallCnt <= '0;
        end else if ((state != ST_IDLE) && fifoEmpty && (stallCnt != 32'hFFFF_FFFF)) begin
            stallCnt <= stallCnt + 32'd1;
        end
    end

    assign fetch_stall_cnt = stallCnt;
`else
    assign fetch_stall_cnt = 32'h0;
`endif

endmodule
